// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  mips_fetch_pkg
//  Shared types and field positions for the MIPS instruction fetch stage.
//  Rev 1.0
// ============================================================================
package mips_fetch_pkg;

    localparam int c_opc_hi = 31;
    localparam int c_opc_lo = 26;
    localparam int c_rs_hi  = 25;
    localparam int c_rs_lo  = 21;
    localparam int c_rt_hi  = 20;
    localparam int c_rt_lo  = 16;
    localparam int c_rd_hi  = 15;
    localparam int c_rd_lo  = 11;
    localparam int c_sh_hi  = 10;
    localparam int c_sh_lo  = 6;
    localparam int c_fn_hi  = 5;
    localparam int c_fn_lo  = 0;
    localparam int c_imm_hi = 15;
    localparam int c_jta_hi = 25;

    localparam logic [31:0] c_nop = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  fetch_fifo
//  Synchronous FIFO with flush; head read straight from storage registers.
//  Rev 1.0
// ============================================================================
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type T_ENTRY = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  T_ENTRY                 i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output T_ENTRY                 o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    T_ENTRY            r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_cw'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cw'(w_do_push) - c_cw'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  instr_fetch_unit
//  Fetch PC, credit-limited imem requests, response buffer, redirect flush.
//  Rev 1.0
// ============================================================================
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic [31:0] PCOut,
    output logic [31:0] PC_In,
    output logic [5:0]  addr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] JTA,
    output logic        err_unexp_rsp
);

    localparam int c_cw = $clog2(DEPTH) + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_cw-1:0] r_inflight;
    logic [c_cw-1:0] r_drop_cnt;
    logic            r_err;

    logic            w_accept;
    logic            w_rsp_live;
    logic            w_rsp_drop;
    logic            w_rsp_err;
    logic            w_credit;
    logic [c_cw-1:0] w_inflight_left;
    logic [c_cw-1:0] w_drop_nxt;
    logic [c_cw-1:0] w_occ;
    logic [31:0]     w_redir_pc;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;

    assign w_redir_pc      = redirect_pc & 32'hFFFF_FFFC;
    assign w_accept        = imem_req_valid && imem_req_ready;
    assign w_rsp_live      = imem_rsp_valid && (r_inflight != '0);
    assign w_rsp_drop      = imem_rsp_valid && (r_inflight == '0) && (r_drop_cnt != '0);
    assign w_rsp_err       = imem_rsp_valid && (r_inflight == '0) && (r_drop_cnt == '0);
    assign w_inflight_left = r_inflight - c_cw'(w_rsp_live);
    assign w_drop_nxt      = r_drop_cnt - c_cw'(w_rsp_drop);
    assign w_credit        = ((r_inflight + w_occ) < c_cw'(DEPTH));

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req_valid = w_credit && !redirect_valid;
                if (redirect_valid && (w_inflight_left != '0)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_drop_nxt == '0) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // r_rsp_pc tracks the PC of the oldest live request so each word is tagged on arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rsp_err) r_err <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_inflight <= '0;
                r_drop_cnt <= w_drop_nxt + w_inflight_left;
            end else begin
                if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp_live) r_rsp_pc   <= r_rsp_pc + 32'd4;
                r_inflight <= w_inflight_left + c_cw'(w_accept);
                r_drop_cnt <= w_drop_nxt;
            end
        end
    end

    assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_rsp_live),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    assign imem_req_addr = r_fetch_pc;
    assign err_unexp_rsp = r_err;
    assign out_valid     = !w_empty;
    assign instruction   = w_empty ? c_nop : w_head.instr;
    assign PCOut         = w_empty ? 32'd0 : w_head.pc;
    assign PC_In         = w_empty ? 32'd0 : (w_head.pc + 32'd4);

    assign addr  = instruction[c_opc_hi:c_opc_lo];
    assign rs    = instruction[c_rs_hi:c_rs_lo];
    assign rt    = instruction[c_rt_hi:c_rt_lo];
    assign rd    = instruction[c_rd_hi:c_rd_lo];
    assign shamt = instruction[c_sh_hi:c_sh_lo];
    assign funct = instruction[c_fn_hi:c_fn_lo];
    assign imm   = instruction[c_imm_hi:0];
    assign JTA   = instruction[c_jta_hi:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  tb_instr_fetch_unit
//  Directed bench with a latency-configurable in-order instruction memory.
//  Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] PCOut;
    logic [31:0] PC_In;
    logic [5:0]  addr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] JTA;
    logic        err_unexp_rsp;

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .PCOut          (PCOut),
        .PC_In          (PC_In),
        .addr           (addr),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .imm            (imm),
        .JTA            (JTA),
        .err_unexp_rsp  (err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    logic [31:0] got_pcin[$];
    int          got_cyc[$];

    int          cyc;
    int          lat;
    logic        force_spur;
    logic        s_req_v;
    logic [31:0] s_req_a;
    logic        s_ov;
    logic [31:0] s_pc;
    logic [31:0] s_ins;
    logic [31:0] s_pcin;
    int          n_chk;
    int          n_err;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h012A_4020 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gpc(input int i);
        if (i < got_pc.size()) return got_pc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] gins(input int i);
        if (i < got_ins.size()) return got_ins[i];
        return 'x;
    endfunction

    function automatic logic [31:0] gacc(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 'x;
    endfunction

    // One clock: drive memory response, sample at negedge, update model after the edge.
    task automatic step();
        if (force_spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend[0].a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        s_req_v = imem_req_valid;
        s_req_a = imem_req_addr;
        s_ov    = out_valid;
        s_pc    = PCOut;
        s_ins   = instruction;
        s_pcin  = PC_In;
        @(posedge clk);
        #1;
        if (imem_rsp_valid && !force_spur) pend.delete(0);
        if (s_req_v && imem_req_ready) begin
            pend.push_back('{a: s_req_a, due: cyc + lat});
            acc_q.push_back(s_req_a);
        end
        if (s_ov && out_ready) begin
            got_pc.push_back(s_pc);
            got_ins.push_back(s_ins);
            got_pcin.push_back(s_pcin);
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic assert_rst();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        force_spur     = 1'b0;
        lat            = 1;
        pend.delete();
        acc_q.delete();
        got_pc.delete();
        got_ins.delete();
        got_pcin.delete();
        got_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   stale;
        int   rcyc;
        logic found;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;

        // Reset values, field split, first-word latency, back-to-back stream
        assert_rst();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pcout", PCOut, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pcin", PC_In, 32'h0);
        chk("rst_err", {31'd0, err_unexp_rsp}, 32'd0);
        reset = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            step();
            n++;
            found = out_valid;
        end
        chk("t1_first_valid_steps", n, 32'd3);
        chk("t1_pcout0", PCOut, 32'h0);
        chk("t1_pcin0", PC_In, 32'h4);
        chk("t1_instr0", instruction, 32'h012A_4020);
        chk("t1_opc", {26'd0, addr}, 32'd0);
        chk("t1_rs", {27'd0, rs}, 32'd9);
        chk("t1_rt", {27'd0, rt}, 32'd10);
        chk("t1_rd", {27'd0, rd}, 32'd8);
        chk("t1_shamt", {27'd0, shamt}, 32'd0);
        chk("t1_funct", {26'd0, funct}, 32'h20);
        chk("t1_imm", {16'd0, imm}, 32'h4020);
        chk("t1_jta", {6'd0, JTA}, 32'h012A_4020);
        repeat (10) step();
        for (int i = 0; i < 6; i++) chk("t1_stream_pc", gpc(i), 32'(i * 4));
        chk("t1_stream_ins3", gins(3), word_of(32'd12));
        chk("t1_back_to_back", (got_cyc.size() > 5) ? 32'(got_cyc[5] - got_cyc[0]) : 32'hFFFF_FFFF, 32'd5);
        chk("t1_no_err", {31'd0, err_unexp_rsp}, 32'd0);

        // Back-pressure: credit limit then ordered release
        assert_rst();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (10) step();
        chk("t2_accepts", acc_q.size(), 32'd4);
        chk("t2_req_idle", {31'd0, imem_req_valid}, 32'd0);
        chk("t2_head_pc", PCOut, 32'h0);
        out_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 5; i++) chk("t2_order_pc", gpc(i), 32'(i * 4));

        // Redirect with two requests in flight, memory latency 3
        assert_rst();
        reset = 1'b1;
        lat = 3;
        found = 1'b0;
        rcyc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0103;
                rcyc = cyc;
                step();
                redirect_valid = 1'b0;
                found = 1'b1;
                chk("t3_req_withdrawn", {31'd0, s_req_v}, 32'd0);
            end else begin
                step();
            end
        end
        chk("t3_redirect_hit", {31'd0, found}, 32'd1);
        repeat (12) step();
        chk("t3_first_pc", gpc(0), 32'h100);
        chk("t3_first_ins", gins(0), word_of(32'h100));
        chk("t3_second_pc", gpc(1), 32'h104);
        chk("t3_drain_latency", (got_cyc.size() > 0) ? 32'(got_cyc[0] - rcyc) : 32'hFFFF_FFFF, 32'd7);
        stale = 0;
        foreach (got_pc[i]) if (got_pc[i] < 32'h100) stale++;
        chk("t3_stale", stale, 32'd0);
        chk("t3_no_err", {31'd0, err_unexp_rsp}, 32'd0);

        // Redirect in the same cycle as the pop of PC 8
        assert_rst();
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (out_valid && PCOut == 32'h8) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
                step();
                redirect_valid = 1'b0;
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("t4_redirect_hit", {31'd0, found}, 32'd1);
        repeat (8) step();
        chk("t4_pc0", gpc(0), 32'h0);
        chk("t4_pc4", gpc(1), 32'h4);
        chk("t4_pc8", gpc(2), 32'h8);
        chk("t4_target", gpc(3), 32'h200);
        chk("t4_target_next", gpc(4), 32'h204);

        // Request stall stability and PC wrap
        assert_rst();
        reset = 1'b1;
        imem_req_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_stall_valid", {31'd0, s_req_v}, 32'd1);
            chk("t5_stall_addr", s_req_a, 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("t5_redir_no_req", {31'd0, s_req_v}, 32'd0);
        imem_req_ready = 1'b1;
        repeat (6) step();
        chk("t5_acc0", gacc(0), 32'hFFFF_FFFC);
        chk("t5_acc1_wrap", gacc(1), 32'h0);
        chk("t5_out_pc", gpc(0), 32'hFFFF_FFFC);
        chk("t5_out_pcin", (got_pcin.size() > 0) ? got_pcin[0] : 32'hFFFF_FFFF, 32'h0);
        chk("t5_out_next", gpc(1), 32'h0);

        // Spurious response with nothing outstanding
        assert_rst();
        reset = 1'b1;
        imem_req_ready = 1'b0;
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        chk("t6_err_set", {31'd0, err_unexp_rsp}, 32'd1);
        chk("t6_no_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) step();
        chk("t6_err_sticky", {31'd0, err_unexp_rsp}, 32'd1);
        chk("t6_still_empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset pulse mid-stream
        assert_rst();
        reset = 1'b1;
        repeat (8) step();
        #3;
        reset = 1'b0;
        #1;
        chk("t7_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("t7_req_addr", imem_req_addr, 32'h0);
        chk("t7_pcout", PCOut, 32'h0);
        chk("t7_instr", instruction, 32'h0);
        chk("t7_funct", {26'd0, funct}, 32'd0);
        imem_rsp_valid = 1'b0;
        pend.delete();
        got_pc.delete();
        got_ins.delete();
        got_pcin.delete();
        got_cyc.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) step();
        chk("t7_restart_pc0", gpc(0), 32'h0);
        chk("t7_restart_pc4", gpc(1), 32'h4);
        chk("t7_no_err", {31'd0, err_unexp_rsp}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
